shape_read: RTL and testbench
=============================

Name: shape_read

Overview:
- Reads one shape record of 2^DATAB words from shape RAM and presents its fields (ty, x, y, size, rotate) as parallel registered outputs.
- The record sits at (id << DATAB) + ram_address_offset.
- Shape writer stores the record; this block is its reader, feeding the renderer and collision logic.
- Reads are pipelined, one address per cycle, against a synchronous RAM of fixed read latency.

Parameters:
- DATAB, 3, log2 of record length in words (record = 8 words; words 0..4 used, 5..7 reserved)
- CORDW, 9, coordinate width for x and y
- ADDRW, 20, RAM address width
- DATAW, 12, RAM word width
- NUMW, DATAW, shape id width
- RAM_LAT, 1, RAM read latency in cycles (≥1): address sampled in cycle c, data valid in cycle c+RAM_LAT

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- id  input  NUMW  shape index, sampled on accepted trigger
- trigger  input  1  start-read request, single-cycle
- ram_address_offset  input  ADDRW  base of shape table, sampled on accepted trigger
- ram_address  output  ADDRW  read address
- ram_enable  output  1  read enable, high only in issue cycles
- ram_data  input  DATAW  read data, valid RAM_LAT cycles after address
- busy  output  1  read in progress
- done  output  1  one-cycle pulse: new field values are on the outputs
- ty  output  DATAW  word 0
- x  output  CORDW  word 1, low CORDW bits
- y  output  CORDW  word 2, low CORDW bits
- size  output  DATAW  word 3
- rotate  output  DATAW  word 4

Behaviour:
- Clock and reset: single clock clk; rst synchronous, active-high, dominant over all other inputs in the same cycle.
- Reset values:
  - state IDLE; busy, done, ram_enable = 0.
  - ty, x, y, size, rotate = 0.
  - Latched base = 0; issue pointer = 0; capture pipeline cleared.
  - ram_address = 0.
- States:
  - IDLE: busy = 0.
  - ISSUE: busy = 1, ram_enable = 1.
  - DRAIN: busy = 1, ram_enable = 0.
  - Transitions: IDLE -> ISSUE on trigger; ISSUE -> DRAIN after the address for word 4; DRAIN -> IDLE when word 4 is captured.
- Trigger acceptance:
  - trigger is accepted only in IDLE; ignored while busy (no queueing).
  - If accepted at the edge ending cycle T: base = (id << DATAB) + ram_address_offset, computed mod 2^ADDRW with id zero-extended; issue pointer = 0.
- Issue:
  - Cycles T+1..T+5: ram_address = base + k for k = 0..4 (mod 2^ADDRW); ram_enable = 1.
  - Words 5..7 are never read.
  - Outside ISSUE, ram_address holds base + last pointer value.
- Capture:
  - A RAM_LAT-deep shift pipeline carries a valid bit and a 3-bit index alongside each issued address.
  - Word k is on ram_data in cycle T+1+k+RAM_LAT and is captured into a shadow register at the end of that cycle.
  - x and y shadows keep ram_data[CORDW-1:0]; upper bits are discarded.
- Commit:
  - Shadow values are copied to all five outputs at the same edge that captures word 4.
  - In cycle T+6+RAM_LAT: done = 1 for exactly one cycle, busy = 0, state = IDLE.
  - Outputs hold until the next commit, never partially updated.
- Latency:
  - trigger to done = 6+RAM_LAT cycles (7 at default).
  - busy high for 5+RAM_LAT cycles.
- Back-to-back reads:
  - trigger is accepted in the done cycle; the next ISSUE starts the following cycle.
  - Minimum spacing between triggers is 6+RAM_LAT cycles.
- Reset mid-read: the read is aborted, in-flight data discarded, outputs cleared to 0, no done pulse.

Test Plan:
- Reset check: assert rst for 2 cycles -> busy = 0, done = 0, ram_enable = 0, all fields = 0.
- Basic read: offset = 0x100, id = 3, RAM words 0x118..0x11C = 0x005, 0x0A0, 0x1FF, 0x020, 0x003 -> addresses 0x118..0x11C in cycles T+1..T+5; done at T+7; ty = 5, x = 160, y = 511, size = 32, rotate = 3.
- Truncation and wrap: word 1 = 0xFFF -> x = 0x1FF. Offset = 0xFFFFC with id = 0 -> addresses 0xFFFFC..0xFFFFF, then 0x00000.
- Trigger while busy: second trigger at T+3 with id = 7 -> ignored, exactly 5 enabled addresses, single done at T+7, fields from id 3.
- Back-to-back: trigger in the done cycle with a new id -> second done exactly 7 cycles later. Outputs keep old values until the second commit.
- Reset mid-read: rst at T+4 -> busy = 0 next cycle, fields = 0, no done. A fresh trigger afterwards completes normally.
- RAM_LAT = 2 build: the basic-read scenario gives done at T+8 with identical field values.

Source files
------------

// File: rtl/shape_read_if.sv
// rtl/shape_read_if.sv - Shape RAM read port bundle
// Ports:
//   ram_address  reader -> RAM  read address
//   ram_enable   reader -> RAM  read enable, one word per enabled cycle
//   ram_data     RAM -> reader  read data, valid RAM_LAT cycles after the address
interface shape_read_if #(
  parameter int ADDRW = 20,
  parameter int DATAW = 12
);
  logic [ADDRW-1:0] ram_address;
  logic             ram_enable;
  logic [DATAW-1:0] ram_data;

  modport master (output ram_address, output ram_enable, input ram_data);
  modport slave  (input ram_address, input ram_enable, output ram_data);
endinterface

// File: rtl/shape_read.sv
// rtl/shape_read.sv - Reads one shape record from shape RAM and presents its fields
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   id                  shape index, sampled on an accepted trigger
//   trigger             single-cycle start request, honoured only when idle
//   ram_address_offset  base of the shape table, sampled on an accepted trigger
//   ram                 RAM read port (address, enable out; data in)
//   busy                read in progress
//   done                one-cycle pulse when new field values appear
//   ty, x, y, size, rotate  record words 0..4 (x, y keep the low CORDW bits)
module shape_read #(
  parameter int DATAB   = 3,
  parameter int CORDW   = 9,
  parameter int ADDRW   = 20,
  parameter int DATAW   = 12,
  parameter int NUMW    = DATAW,
  parameter int RAM_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUMW-1:0]  id,
  input  logic             trigger,
  input  logic [ADDRW-1:0] ram_address_offset,
  shape_read_if.master     ram,
  output logic             busy,
  output logic             done,
  output logic [DATAW-1:0] ty,
  output logic [CORDW-1:0] x,
  output logic [CORDW-1:0] y,
  output logic [DATAW-1:0] size,
  output logic [DATAW-1:0] rotate
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                     state;
  logic [ADDRW-1:0]           base;
  logic [2:0]                 ptr;

  // Each issued address travels with a valid bit and its word index, so the
  // returning data can be steered without knowing how long ago it was issued.
  logic [RAM_LAT-1:0]         pipe_v;
  logic [RAM_LAT-1:0][2:0]    pipe_idx;

  logic [DATAW-1:0]           ty_s;
  logic [CORDW-1:0]           x_s;
  logic [CORDW-1:0]           y_s;
  logic [DATAW-1:0]           size_s;

  logic                       cap_v;
  logic [2:0]                 cap_idx;
  logic                       last_word;
  logic [ADDRW-1:0]           trig_base;

  assign cap_v     = pipe_v[RAM_LAT-1];
  assign cap_idx   = pipe_idx[RAM_LAT-1];
  assign last_word = cap_v && (cap_idx == 3'd4);
  assign trig_base = (ADDRW'(id) << DATAB) + ram_address_offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      base            <= '0;
      ptr             <= '0;
      pipe_v          <= '0;
      pipe_idx        <= '0;
      ty_s            <= '0;
      x_s             <= '0;
      y_s             <= '0;
      size_s          <= '0;
      ty              <= '0;
      x               <= '0;
      y               <= '0;
      size            <= '0;
      rotate          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      ram.ram_enable  <= 1'b0;
      ram.ram_address <= '0;
    end else begin
      pipe_v[0]   <= ram.ram_enable;
      pipe_idx[0] <= ptr;
      for (int i = 1; i < RAM_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_idx[i] <= pipe_idx[i-1];
      end

      done <= 1'b0;

      if (cap_v) begin
        case (cap_idx)
          3'd0:    ty_s   <= ram.ram_data;
          3'd1:    x_s    <= ram.ram_data[CORDW-1:0];
          3'd2:    y_s    <= ram.ram_data[CORDW-1:0];
          3'd3:    size_s <= ram.ram_data;
          default: ;
        endcase
      end

      // Word 4 goes straight to its output so every field updates together.
      if (last_word) begin
        ty     <= ty_s;
        x      <= x_s;
        y      <= y_s;
        size   <= size_s;
        rotate <= ram.ram_data;
      end

      case (state)
        IDLE: begin
          if (trigger) begin
            base            <= trig_base;
            ptr             <= '0;
            ram.ram_address <= trig_base;
            ram.ram_enable  <= 1'b1;
            busy            <= 1'b1;
            state           <= ISSUE;
          end
        end
        ISSUE: begin
          if (ptr == 3'd4) begin
            ram.ram_enable <= 1'b0;
            state          <= DRAIN;
          end else begin
            ptr             <= ptr + 3'd1;
            ram.ram_address <= base + ADDRW'(ptr + 3'd1);
          end
        end
        DRAIN: begin
          if (last_word) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shape_read.sv
// tb/tb_shape_read.sv - Scoreboard bench for shape_read at RAM_LAT 1 and 2
module tb_shape_read;
  localparam int ADDRW = 20;
  localparam int DATAW = 12;
  localparam int CORDW = 9;

  typedef struct {
    logic [53:0] f;
    int          cyc;
  } rec_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             trigger = 1'b0;
  logic             trigger2 = 1'b0;
  logic [11:0]      id = '0;
  logic [19:0]      offset = '0;
  logic             busy1, done1, busy2, done2;
  logic [11:0]      ty1, size1, rot1, ty2, size2, rot2;
  logic [8:0]       x1, y1, x2, y2;
  logic [11:0]      d2_s0;
  logic [11:0]      mem [int];
  int               cyc = 0;
  int               passed = 0;
  int               total = 0;
  logic [19:0]      exp_addr [$];
  rec_t             exp_rec [$];

  shape_read_if #(.ADDRW(ADDRW), .DATAW(DATAW)) ram1 ();
  shape_read_if #(.ADDRW(ADDRW), .DATAW(DATAW)) ram2 ();

  shape_read #(.RAM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .id(id), .trigger(trigger), .ram_address_offset(offset),
    .ram(ram1), .busy(busy1), .done(done1), .ty(ty1), .x(x1), .y(y1),
    .size(size1), .rotate(rot1)
  );

  shape_read #(.RAM_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .id(id), .trigger(trigger2), .ram_address_offset(offset),
    .ram(ram2), .busy(busy2), .done(done2), .ty(ty2), .x(x2), .y(y2),
    .size(size2), .rotate(rot2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] rd(input logic [19:0] a);
    return mem.exists(int'(a)) ? mem[int'(a)] : 12'h000;
  endfunction

  // Sync RAM models; 0xBAD appears whenever no read was issued.
  always @(posedge clk) begin
    ram1.ram_data <= ram1.ram_enable ? rd(ram1.ram_address) : 12'hBAD;
    d2_s0         <= ram2.ram_enable ? rd(ram2.ram_address) : 12'hBAD;
    ram2.ram_data <= d2_s0;
  end

  function automatic logic [53:0] pk(input logic [11:0] t, input logic [8:0] a,
                                     input logic [8:0] b, input logic [11:0] s,
                                     input logic [11:0] r);
    return {t, a, b, s, r};
  endfunction

  function automatic logic [53:0] f1();
    return {ty1, x1, y1, size1, rot1};
  endfunction

  function automatic logic [53:0] f2();
    return {ty2, x2, y2, size2, rot2};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({busy1, done1, ram1.ram_enable} !== 3'b000 || f1() !== 54'd0 || ram1.ram_address !== 20'd0)
      $display("FAIL reset1: busy/done/en %b fields %h addr %h, want all 0", {busy1, done1, ram1.ram_enable}, f1(), ram1.ram_address);
    else passed++;
    total++;
    if ({busy2, done2, ram2.ram_enable} !== 3'b000 || f2() !== 54'd0)
      $display("FAIL reset2: busy/done/en %b fields %h, want all 0", {busy2, done2, ram2.ram_enable}, f2());
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_reads();
    logic [11:0] ids [3];
    logic [19:0] offs [3];
    logic [19:0] bases [3];
    logic [11:0] wd [3][5];
    logic [53:0] exps [3];
    logic [19:0] a;
    rec_t        r;
    int          t;
    ids   = '{12'd3, 12'd0, 12'hFFF};
    offs  = '{20'h00100, 20'hFFFFC, 20'h12345};
    bases = '{20'h00118, 20'hFFFFC, 20'h1A33D};
    wd    = '{'{12'h005, 12'h0A0, 12'h1FF, 12'h020, 12'h003},
              '{12'h7AB, 12'hFFF, 12'hE35, 12'h800, 12'hC01},
              '{12'h111, 12'h2A5, 12'h3C3, 12'h444, 12'h555}};
    exps  = '{pk(12'h005, 9'h0A0, 9'h1FF, 12'h020, 12'h003),
              pk(12'h7AB, 9'h1FF, 9'h035, 12'h800, 12'hC01),
              pk(12'h111, 9'h0A5, 9'h1C3, 12'h444, 12'h555)};
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 5; k++) begin
        a = bases[s] + 20'(k);
        mem[int'(a)] = wd[s][k];
        exp_addr.push_back(a);
      end
      @(negedge clk);
      id = ids[s]; offset = offs[s]; trigger = 1'b1; t = cyc;
      exp_rec.push_back('{exps[s], t + 7});
      for (int c = 1; c <= 10; c++) begin
        @(negedge clk);
        trigger = 1'b0;
        if (ram1.ram_enable) begin
          total++;
          if (exp_addr.size() == 0) $display("FAIL read%0d addr: enable at cycle %0d addr %h, want none", s, cyc, ram1.ram_address);
          else begin
            a = exp_addr.pop_front();
            if (ram1.ram_address !== a) $display("FAIL read%0d addr: got %h want %h", s, ram1.ram_address, a);
            else passed++;
          end
        end
        if (done1) begin
          total++;
          if (exp_rec.size() == 0) $display("FAIL read%0d done: extra done at cycle %0d, want none", s, cyc);
          else begin
            r = exp_rec.pop_front();
            if (f1() !== r.f || cyc != r.cyc) $display("FAIL read%0d done: fields %h at %0d want %h at %0d", s, f1(), cyc, r.f, r.cyc);
            else passed++;
          end
        end
      end
      total++;
      if (exp_addr.size() != 0 || exp_rec.size() != 0)
        $display("FAIL read%0d drain: %0d addrs %0d dones outstanding, want 0 0", s, exp_addr.size(), exp_rec.size());
      else passed++;
    end
  endtask

  task automatic test_busy_trigger();
    logic [19:0] a;
    rec_t        r;
    int          t;
    int          en_n = 0;
    for (int k = 0; k < 5; k++) begin
      mem[int'(20'h138) + k] = 12'hE00 + 12'(k);
      exp_addr.push_back(20'h118 + 20'(k));
    end
    @(negedge clk);
    id = 12'd3; offset = 20'h100; trigger = 1'b1; t = cyc;
    exp_rec.push_back('{pk(12'h005, 9'h0A0, 9'h1FF, 12'h020, 12'h003), t + 7});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      trigger = (c == 3);
      id = (c == 3) ? 12'd7 : 12'd3;
      if (c == 3) begin
        total++;
        if (busy1 !== 1'b1) $display("FAIL busy_mid: busy %b want 1", busy1);
        else passed++;
      end
      if (ram1.ram_enable) begin
        en_n++;
        total++;
        if (exp_addr.size() == 0) $display("FAIL busy addr: enable at cycle %0d addr %h, want none", cyc, ram1.ram_address);
        else begin
          a = exp_addr.pop_front();
          if (ram1.ram_address !== a) $display("FAIL busy addr: got %h want %h", ram1.ram_address, a);
          else passed++;
        end
      end
      if (done1) begin
        total++;
        if (exp_rec.size() == 0) $display("FAIL busy done: extra done at cycle %0d, want none", cyc);
        else begin
          r = exp_rec.pop_front();
          if (f1() !== r.f || cyc != r.cyc) $display("FAIL busy done: fields %h at %0d want %h at %0d", f1(), cyc, r.f, r.cyc);
          else passed++;
        end
      end
    end
    total++;
    if (en_n != 5 || exp_rec.size() != 0) $display("FAIL busy count: %0d enables %0d dones missing, want 5 0", en_n, exp_rec.size());
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [19:0] a;
    logic [53:0] fa;
    rec_t        r;
    int          t;
    logic [11:0] wb [5];
    wb = '{12'h011, 12'h1C3, 12'h0F0, 12'h00F, 12'h2AA};
    fa = pk(12'h005, 9'h0A0, 9'h1FF, 12'h020, 12'h003);
    for (int k = 0; k < 5; k++) begin
      mem[int'(20'h128) + k] = wb[k];
      exp_addr.push_back(20'h118 + 20'(k));
    end
    @(negedge clk);
    id = 12'd3; offset = 20'h100; trigger = 1'b1; t = cyc;
    exp_rec.push_back('{fa, t + 7});
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      trigger = 1'b0;
      if (ram1.ram_enable) begin
        total++;
        if (exp_addr.size() == 0) $display("FAIL b2b addr: enable at cycle %0d addr %h, want none", cyc, ram1.ram_address);
        else begin
          a = exp_addr.pop_front();
          if (ram1.ram_address !== a) $display("FAIL b2b addr: got %h want %h", ram1.ram_address, a);
          else passed++;
        end
      end
      if (done1) begin
        total++;
        if (exp_rec.size() == 0) $display("FAIL b2b done: extra done at cycle %0d, want none", cyc);
        else begin
          r = exp_rec.pop_front();
          if (f1() !== r.f || cyc != r.cyc) $display("FAIL b2b done: fields %h at %0d want %h at %0d", f1(), cyc, r.f, r.cyc);
          else passed++;
        end
      end
      if (c == 13) begin
        total++;
        if (f1() !== fa) $display("FAIL b2b hold: fields %h want %h", f1(), fa);
        else passed++;
      end
      if (c == 7) begin
        id = 12'd5; trigger = 1'b1;
        for (int k = 0; k < 5; k++) exp_addr.push_back(20'h128 + 20'(k));
        exp_rec.push_back('{pk(12'h011, 9'h1C3, 9'h0F0, 12'h00F, 12'h2AA), t + 14});
      end
    end
    total++;
    if (exp_addr.size() != 0 || exp_rec.size() != 0)
      $display("FAIL b2b drain: %0d addrs %0d dones outstanding, want 0 0", exp_addr.size(), exp_rec.size());
    else passed++;
  endtask

  task automatic test_reset_mid();
    int extra_done = 0;
    @(negedge clk);
    id = 12'd3; offset = 20'h100; trigger = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      trigger = 1'b0;
      if (done1) extra_done++;
      if (c == 4) rst = 1'b1;
      if (c == 5) begin
        rst = 1'b0;
        total++;
        if ({busy1, done1, ram1.ram_enable} !== 3'b000 || f1() !== 54'd0)
          $display("FAIL rst_mid: busy/done/en %b fields %h, want 000 and 0", {busy1, done1, ram1.ram_enable}, f1());
        else passed++;
      end
    end
    total++;
    if (extra_done != 0 || f1() !== 54'd0) $display("FAIL rst_mid quiet: %0d dones fields %h, want 0 and 0", extra_done, f1());
    else passed++;
  endtask

  task automatic test_lat2();
    logic [19:0] a;
    rec_t        r;
    int          t;
    for (int k = 0; k < 5; k++) exp_addr.push_back(20'h118 + 20'(k));
    @(negedge clk);
    id = 12'd3; offset = 20'h100; trigger2 = 1'b1; t = cyc;
    exp_rec.push_back('{pk(12'h005, 9'h0A0, 9'h1FF, 12'h020, 12'h003), t + 8});
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      trigger2 = 1'b0;
      if (ram2.ram_enable) begin
        total++;
        if (exp_addr.size() == 0) $display("FAIL lat2 addr: enable at cycle %0d addr %h, want none", cyc, ram2.ram_address);
        else begin
          a = exp_addr.pop_front();
          if (ram2.ram_address !== a) $display("FAIL lat2 addr: got %h want %h", ram2.ram_address, a);
          else passed++;
        end
      end
      if (done2) begin
        total++;
        if (exp_rec.size() == 0) $display("FAIL lat2 done: extra done at cycle %0d, want none", cyc);
        else begin
          r = exp_rec.pop_front();
          if (f2() !== r.f || cyc != r.cyc) $display("FAIL lat2 done: fields %h at %0d want %h at %0d", f2(), cyc, r.f, r.cyc);
          else passed++;
        end
      end
    end
    total++;
    if (exp_addr.size() != 0 || exp_rec.size() != 0)
      $display("FAIL lat2 drain: %0d addrs %0d dones outstanding, want 0 0", exp_addr.size(), exp_rec.size());
    else passed++;
  endtask

  initial begin
    test_reset();
    test_reads();
    test_busy_trigger();
    test_back_to_back();
    test_reset_mid();
    test_reads();
    test_lat2();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
